// File: rtl/sha_block_scheduler.sv
// sha_block_scheduler: shares one SHA hash core between NUM_REQ requesters.
// Arbitration is round-robin per whole message. The owner keeps the core
// until its last block is hashed and its digest (or timeout error) is consumed.
module sha_block_scheduler #(
    parameter int NUM_REQ  = 2,
    parameter int BLOCK_W  = 512,
    parameter int DIGEST_W = 256,
    parameter int TIMEOUT  = 1024,
    parameter bit SEL_MODE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_first,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_block,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [DIGEST_W-1:0]        rsp_digest,
    output logic                       rsp_err,
    output logic [BLOCK_W-1:0]         core_block,
    output logic                       core_init,
    output logic                       core_next,
    output logic                       core_sel,
    input  logic                       core_ready,
    input  logic [DIGEST_W-1:0]        core_digest,
    input  logic                       core_digest_valid
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_rr;
    logic [IDX_W-1:0] r_owner;
    logic             r_first_blk;  // next accepted block is the first of this lock
    logic             r_last;       // block in flight is the last of the message
    logic             r_seen_low;   // digest_valid observed low since the pulse
    logic [TMR_W-1:0] r_timer;

    logic               w_grant_found;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic [BLOCK_W-1:0] w_owner_block;
    logic               w_owner_valid;
    logic               w_owner_first;
    logic               w_owner_last;
    logic               w_owner_rsp_ready;
    logic               w_accept;
    logic               w_done;
    logic               w_timeout;
    logic               w_rsp_taken;

    // First valid requester at or after the pointer, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[idx]) pick = IDX_W'(idx);
        end
        return pick;
    endfunction

    assign core_sel      = SEL_MODE;
    assign w_grant_found = |req_valid;
    assign w_grant_idx   = rr_pick(req_valid, r_rr);
    assign w_rr_nxt      = IDX_W'((int'(w_grant_idx) + 1) % NUM_REQ);

    // Route the owner's request and response-handshake lines.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_owner_block     = '0;
        w_owner_valid     = 1'b0;
        w_owner_first     = 1'b0;
        w_owner_last      = 1'b0;
        w_owner_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_owner_block     = req_block[i*BLOCK_W +: BLOCK_W];
                w_owner_valid     = req_valid[i];
                w_owner_first     = req_first[i];
                w_owner_last      = req_last[i];
                w_owner_rsp_ready = rsp_ready[i];
            end
        end
    end

    assign w_accept    = (r_state == S_ISSUE) && core_ready && w_owner_valid;
    assign w_done      = (r_state == S_WAIT) && r_seen_low && core_digest_valid;
    assign w_timeout   = (r_state == S_WAIT) && !w_done && (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_rsp_taken = (r_state == S_RESP) && w_owner_rsp_ready;

    // Accept pulse goes to the owner only, in the cycle the block is taken.
    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[r_owner] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_found) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_accept)      w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_done)         w_state_nxt = r_last ? S_RESP : S_ISSUE;
                else if (w_timeout) w_state_nxt = S_RESP;
            end
            S_RESP:  if (w_rsp_taken)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant bookkeeping, core pulses, completion tracking and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= '0;
            r_owner     <= '0;
            r_first_blk <= 1'b0;
            r_last      <= 1'b0;
            r_seen_low  <= 1'b0;
            r_timer     <= '0;
            core_block  <= '0;
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            rsp_valid   <= '0;
            rsp_digest  <= '0;
            rsp_err     <= 1'b0;
        end else begin
            core_init <= 1'b0;
            core_next <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        r_owner     <= w_grant_idx;
                        r_rr        <= w_rr_nxt;
                        r_first_blk <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        core_block  <= w_owner_block;
                        core_init   <= r_first_blk | w_owner_first;
                        core_next   <= ~(r_first_blk | w_owner_first);
                        r_first_blk <= 1'b0;
                        r_last      <= w_owner_last;
                        r_timer     <= '0;
                        r_seen_low  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // A stale digest_valid from the prior block must drop before it counts.
                    if (!core_digest_valid) r_seen_low <= 1'b1;
                    if (w_done) begin
                        if (r_last) begin
                            rsp_digest         <= core_digest;
                            rsp_err            <= 1'b0;
                            rsp_valid[r_owner] <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        rsp_digest         <= '0;
                        rsp_err            <= 1'b1;
                        rsp_valid[r_owner] <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_taken) begin
                        rsp_valid <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
